bht_storage: RTL and testbench

- Branch history table storage array. It is the receiving end of the BJU's BHT write interface (bjusb_bht_*).
- Holds 2^BHTBTB_INDEX_WIDTH sets of four 2-bit saturating counters.
- Applies resolved-branch increment/decrement updates from the BJU.
- Serves registered set reads to the frontend predictor.
- An init sequencer sweeps the array to weakly-not-taken after reset or flush.

---
 rtl/bht_storage_pkg.sv | 25 ++
 rtl/bht_storage_if.sv | 42 ++++
 rtl/bht_storage_sat_cnt.sv | 29 ++
 rtl/bht_storage.sv | 134 +++++++++++++
 tb/tb_bht_storage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bht_storage_pkg.sv
// =============================================================================
// Module   : bpu_pkg
// Brief    : Shared types and constants for the branch history table storage.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package bpu_pkg;

  localparam int                   BHT_SETS     = 512;
  localparam int                   BHT_CNT_W    = 2;
  localparam int                   BHT_WAYS     = 4;
  localparam logic [BHT_CNT_W-1:0] BHT_INIT_CNT = 2'b01;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } bht_state_e;

  // One set: four 2-bit counters, slot 0 in the least significant bits.
  typedef logic [BHT_WAYS-1:0][BHT_CNT_W-1:0] bht_set_t;

endpackage

`default_nettype wire

// File: rtl/bht_storage_if.sv
// =============================================================================
// Module   : bht_storage_if
// Brief    : BJU update bus, flush, frontend read port and ready of the BHT.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface bht_storage_if #(
  parameter int IDX_W = 9
);

  logic             bjusb_bht_write_enable;
  logic             bjusb_bht_valid_in;
  logic [IDX_W-1:0] bjusb_bht_write_index;
  logic [1:0]       bjusb_bht_write_counter_select;
  logic             bjusb_bht_write_inc;
  logic             bjusb_bht_write_dec;
  logic             bht_flush;
  logic             pred_rd_valid;
  logic [IDX_W-1:0] pred_rd_index;
  logic             pred_rd_data_valid;
  logic [7:0]       pred_rd_counters;
  logic [3:0]       pred_rd_taken;
  logic             bht_ready;

  modport master (
    output bjusb_bht_write_enable, bjusb_bht_valid_in, bjusb_bht_write_index,
           bjusb_bht_write_counter_select, bjusb_bht_write_inc, bjusb_bht_write_dec,
           bht_flush, pred_rd_valid, pred_rd_index,
    input  pred_rd_data_valid, pred_rd_counters, pred_rd_taken, bht_ready
  );

  modport slave (
    input  bjusb_bht_write_enable, bjusb_bht_valid_in, bjusb_bht_write_index,
           bjusb_bht_write_counter_select, bjusb_bht_write_inc, bjusb_bht_write_dec,
           bht_flush, pred_rd_valid, pred_rd_index,
    output pred_rd_data_valid, pred_rd_counters, pred_rd_taken, bht_ready
  );

endinterface

`default_nettype wire

// File: rtl/bht_storage_sat_cnt.sv
// =============================================================================
// Module   : bht_sat_cnt
// Brief    : 2-bit saturating counter increment/decrement (combinational).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module bht_sat_cnt
  import bpu_pkg::*;
(
  input  logic [BHT_CNT_W-1:0] cnt_in,
  input  logic                 inc,
  input  logic                 dec,
  output logic [BHT_CNT_W-1:0] cnt_out
);

  // Saturate at both ends; conflicting or absent requests leave the count alone.
  always_comb begin
    cnt_out = cnt_in;
    if (inc && !dec && (cnt_in != '1)) begin
      cnt_out = cnt_in + 1'b1;
    end else if (dec && !inc && (cnt_in != '0)) begin
      cnt_out = cnt_in - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bht_storage.sv
// =============================================================================
// Module   : bht_storage
// Brief    : Branch history table array: init sweep, BJU counter updates and
//            registered frontend set reads with write-first bypass.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module bht_storage #(
  parameter int         BHTBTB_INDEX_WIDTH = 9,
  parameter logic [1:0] BHT_INIT_CNT       = 2'b01
) (
  input  logic         clock,
  input  logic         reset_n,
  bht_storage_if.slave bus
);

  import bpu_pkg::*;

  localparam int SETS = 1 << BHTBTB_INDEX_WIDTH;
  localparam logic [BHTBTB_INDEX_WIDTH:0] LAST_PTR = (BHTBTB_INDEX_WIDTH + 1)'(SETS - 1);

  bht_state_e                    r_state;
  bht_state_e                    w_state_nxt;
  logic [BHTBTB_INDEX_WIDTH:0]   r_sweep_ptr;
  logic [BHTBTB_INDEX_WIDTH:0]   w_sweep_ptr_nxt;
  bht_set_t                      r_bht [SETS];

  logic                          w_upd_fire;
  bht_set_t                      w_cur_set;
  bht_set_t                      w_upd_set;
  logic [BHT_CNT_W-1:0]          w_cur_cnt;
  logic [BHT_CNT_W-1:0]          w_new_cnt;

  logic                          w_rd_serve;
  bht_set_t                      w_rd_set;
  logic                          r_rd_data_valid;
  logic [7:0]                    r_rd_counters;

  // A flush in the same cycle wins over the update; INIT drops updates.
  assign w_upd_fire = (r_state == IDLE) && bus.bjusb_bht_write_enable &&
                      bus.bjusb_bht_valid_in && !bus.bht_flush;

  assign w_cur_set = r_bht[bus.bjusb_bht_write_index];
  assign w_cur_cnt = w_cur_set[bus.bjusb_bht_write_counter_select];

  bht_sat_cnt u_sat_cnt (
    .cnt_in  (w_cur_cnt),
    .inc     (bus.bjusb_bht_write_inc),
    .dec     (bus.bjusb_bht_write_dec),
    .cnt_out (w_new_cnt)
  );

  // Rebuild the set with only the selected counter replaced.
  always_comb begin
    w_upd_set = w_cur_set;
    w_upd_set[bus.bjusb_bht_write_counter_select] = w_new_cnt;
  end

  // Next-state logic: sweep every set once, flush restarts the sweep.
  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_ptr_nxt = r_sweep_ptr;
    case (r_state)
      INIT: begin
        if (bus.bht_flush || (r_sweep_ptr == LAST_PTR)) begin
          w_sweep_ptr_nxt = '0;
          w_state_nxt     = bus.bht_flush ? INIT : IDLE;
        end else begin
          w_sweep_ptr_nxt = r_sweep_ptr + 1'b1;
        end
      end
      IDLE: begin
        if (bus.bht_flush) begin
          w_state_nxt     = INIT;
          w_sweep_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = INIT;
        w_sweep_ptr_nxt = '0;
      end
    endcase
  end

  // State and sweep pointer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= INIT;
      r_sweep_ptr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_ptr <= w_sweep_ptr_nxt;
    end
  end

  // Counter array: sweep writes during INIT, BJU updates during IDLE.
  always_ff @(posedge clock) begin
    if (r_state == INIT) begin
      r_bht[r_sweep_ptr[BHTBTB_INDEX_WIDTH-1:0]] <= {BHT_WAYS{BHT_INIT_CNT}};
    end else if (w_upd_fire) begin
      r_bht[bus.bjusb_bht_write_index] <= w_upd_set;
    end
  end

  // Reads are served only in a steady IDLE cycle; same-index update bypasses.
  assign w_rd_serve = bus.pred_rd_valid && (r_state == IDLE) && !bus.bht_flush;
  assign w_rd_set   = (w_upd_fire && (bus.bjusb_bht_write_index == bus.pred_rd_index))
                      ? w_upd_set : r_bht[bus.pred_rd_index];

  // Read register: holds last data when idle, zeroes on a refused read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data_valid <= 1'b0;
      r_rd_counters   <= '0;
    end else begin
      r_rd_data_valid <= w_rd_serve;
      if (bus.pred_rd_valid) begin
        r_rd_counters <= w_rd_serve ? w_rd_set : '0;
      end
    end
  end

  assign bus.pred_rd_data_valid = r_rd_data_valid;
  assign bus.pred_rd_counters   = r_rd_counters;
  assign bus.bht_ready          = (r_state == IDLE);

  for (genvar gi = 0; gi < BHT_WAYS; gi++) begin : g_taken
    assign bus.pred_rd_taken[gi] = r_rd_counters[gi*BHT_CNT_W + BHT_CNT_W - 1];
  end

endmodule

`default_nettype wire

// File: tb/tb_bht_storage.sv
// =============================================================================
// Module   : tb_bht_storage
// Brief    : Scoreboard bench for bht_storage with directed read/update vectors.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_bht_storage;

  typedef struct {
    logic [7:0] counters;
    logic [3:0] taken;
    int         due;
  } rd_exp_t;

  logic    clock;
  logic    reset_n;
  int      cyc;
  int      n_cmp;
  int      n_fail;
  rd_exp_t exp_q[$];

  bht_storage_if #(.IDX_W(9)) bus ();

  bht_storage #(
    .BHTBTB_INDEX_WIDTH (9),
    .BHT_INIT_CNT       (2'b01)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.bjusb_bht_write_enable         = 1'b0;
    bus.bjusb_bht_valid_in             = 1'b0;
    bus.bjusb_bht_write_index          = '0;
    bus.bjusb_bht_write_counter_select = '0;
    bus.bjusb_bht_write_inc            = 1'b0;
    bus.bjusb_bht_write_dec            = 1'b0;
    bus.bht_flush                      = 1'b0;
    bus.pred_rd_valid                  = 1'b0;
    bus.pred_rd_index                  = '0;
  endtask

  task automatic set_upd(input int idx, input int sel, input bit inc, input bit dec);
    bus.bjusb_bht_write_enable         = 1'b1;
    bus.bjusb_bht_valid_in             = 1'b1;
    bus.bjusb_bht_write_index          = 9'(idx);
    bus.bjusb_bht_write_counter_select = 2'(sel);
    bus.bjusb_bht_write_inc            = inc;
    bus.bjusb_bht_write_dec            = dec;
  endtask

  // Issue a read that must be served; expected data goes to the scoreboard.
  task automatic set_rd(input int idx, input logic [7:0] c, input logic [3:0] t);
    rd_exp_t e;
    bus.pred_rd_valid = 1'b1;
    bus.pred_rd_index = 9'(idx);
    e.counters = c;
    e.taken    = t;
    e.due      = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic do_upd(input int idx, input int sel, input bit inc, input bit dec);
    set_upd(idx, sel, inc, dec);
    tick();
    clear_inputs();
  endtask

  task automatic do_read(input int idx, input logic [7:0] c, input logic [3:0] t);
    set_rd(idx, c, t);
    tick();
    clear_inputs();
  endtask

  task automatic wait_ready(input string name, input int req);
    int n;
    n = 0;
    while (!bus.bht_ready && n < 2000) begin
      tick();
      n++;
    end
    chk(name, n, req);
  endtask

  // Monitor: every valid read output must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.pred_rd_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rd: data valid with counters %0h, expected none", bus.pred_rd_counters);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        chk("rd_counters", bus.pred_rd_counters, e.counters);
        chk("rd_taken", bus.pred_rd_taken, e.taken);
        chk("rd_latency", cyc, e.due);
      end
    end
  end

  initial begin
    cyc     = 0;
    n_cmp   = 0;
    n_fail  = 0;
    reset_n = 1'b1;
    clear_inputs();
    #3 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", bus.bht_ready, 0);
    chk("rst_dvalid", bus.pred_rd_data_valid, 0);
    chk("rst_counters", bus.pred_rd_counters, 0);
    chk("rst_taken", bus.pred_rd_taken, 0);
    reset_n = 1'b1;
    wait_ready("init_sweep_len", 512);

    do_read(0, 8'h55, 4'b0000);
    do_read(511, 8'h55, 4'b0000);
    tick();
    chk("hold_dvalid", bus.pred_rd_data_valid, 0);
    chk("hold_counters", bus.pred_rd_counters, 8'h55);

    // Increment saturation on index 7 slot 2.
    do_upd(7, 2, 1, 0); do_read(7, 8'h65, 4'b0100);
    do_upd(7, 2, 1, 0); do_read(7, 8'h75, 4'b0100);
    do_upd(7, 2, 1, 0); do_read(7, 8'h75, 4'b0100);
    do_upd(7, 2, 1, 0); do_read(7, 8'h75, 4'b0100);

    // Decrement saturation on index 3 slot 0, then inc&dec on slot 1.
    do_upd(3, 0, 0, 1); do_read(3, 8'h54, 4'b0000);
    do_upd(3, 0, 0, 1); do_read(3, 8'h54, 4'b0000);
    do_upd(3, 0, 0, 1); do_read(3, 8'h54, 4'b0000);
    do_upd(3, 1, 1, 1); do_read(3, 8'h54, 4'b0000);

    // Write-first bypass, then an unrelated read alongside an update.
    set_upd(5, 3, 1, 0); set_rd(5, 8'h95, 4'b1000); tick(); clear_inputs();
    set_upd(5, 3, 1, 0); set_rd(6, 8'h55, 4'b0000); tick(); clear_inputs();
    do_read(5, 8'hD5, 4'b1000);

    // Flush from IDLE with a same-cycle read: refused, data cleared.
    bus.bht_flush = 1'b1;
    bus.pred_rd_valid = 1'b1;
    bus.pred_rd_index = 9'd5;
    tick();
    clear_inputs();
    chk("flush_ready", bus.bht_ready, 0);
    chk("flush_rd_dvalid", bus.pred_rd_data_valid, 0);
    chk("flush_rd_counters", bus.pred_rd_counters, 0);

    // Mid-sweep: a dropped update to index 0 and a refused read, then re-flush at 200.
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        set_upd(0, 0, 1, 0);
        bus.pred_rd_valid = 1'b1;
        bus.pred_rd_index = 9'd7;
      end
      tick();
      clear_inputs();
      if (i == 100) begin
        chk("init_rd_dvalid", bus.pred_rd_data_valid, 0);
        chk("init_rd_counters", bus.pred_rd_counters, 0);
      end
    end
    bus.bht_flush = 1'b1;
    tick();
    clear_inputs();
    wait_ready("flush_restart_len", 512);
    do_read(7, 8'h55, 4'b0000);
    do_read(0, 8'h55, 4'b0000);

    // Asynchronous reset mid-sweep clears outputs at once and restarts the sweep.
    do_upd(5, 3, 1, 0);
    do_read(5, 8'h95, 4'b1000);
    bus.bht_flush = 1'b1;
    tick();
    clear_inputs();
    repeat (100) tick();
    chk("presrst_counters", bus.pred_rd_counters, 8'h95);
    reset_n = 1'b0;
    #1;
    chk("arst_counters", bus.pred_rd_counters, 0);
    chk("arst_taken", bus.pred_rd_taken, 0);
    chk("arst_ready", bus.bht_ready, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    wait_ready("arst_sweep_len", 512);
    do_read(5, 8'h55, 4'b0000);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
